// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port: pipeline results win, long-latency
// results are queued in a squashable FIFO and drained in free cycles. Define WB_PENDING_CHECK_EN for RAW pending outputs.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_rd,
  input  logic [31:0]   pipe_data,
  input  logic          lu_valid,
  input  logic [4:0]    lu_rd,
  input  logic [31:0]   lu_data,
  output logic          lu_ready,
  output logic          WriteEn,
  output logic [4:0]    rdAddress,
  output logic [31:0]   Write_Back,
`ifdef WB_PENDING_CHECK_EN
  input  logic [4:0]    chk_rs,
  input  logic [4:0]    chk_rt,
  output logic          rs_pending,
  output logic          rt_pending,
`endif
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_DEPTH-1:0] r_vld;
  logic [4:0]            r_rd   [FIFO_DEPTH];
  logic [31:0]           r_data [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_pipe_req;
  logic w_xfer;
  logic w_push;
  logic w_pop;
  logic w_head_vld;

  // Request decode: writes to r0 never reach the port or the queue
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign lu_ready   = !reset && !w_full;
  assign fifo_count = r_count;

  assign w_pipe_req = pipe_we && (pipe_rd != 5'd0);
  assign w_xfer     = lu_valid && lu_ready;
  assign w_push     = w_xfer && (lu_rd != 5'd0);
  assign w_pop      = !w_pipe_req && !w_empty;
  assign w_head_vld = r_vld[r_rptr];

  // Control state: valid bits, pointers, occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // A pipe write makes any older queued result to the same register obsolete
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_pipe_req && (r_rd[i] == pipe_rd)) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      // Same-cycle enqueue is newer than the pipe write, so it overrides the squash
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Queue payload storage needs no reset: the valid bits qualify it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= lu_rd;
      r_data[r_wptr] <= lu_data;
    end
  end

  // Output register stage feeding the register-file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      WriteEn    <= 1'b0;
      rdAddress  <= 5'd0;
      Write_Back <= 32'd0;
    end else if (w_pipe_req) begin
      WriteEn    <= 1'b1;
      rdAddress  <= pipe_rd;
      Write_Back <= pipe_data;
    end else if (w_pop && w_head_vld) begin
      WriteEn    <= 1'b1;
      rdAddress  <= r_rd[r_rptr];
      Write_Back <= r_data[r_rptr];
    end else begin
      WriteEn    <= 1'b0;
      rdAddress  <= 5'd0;
      Write_Back <= 32'd0;
    end
  end

`ifdef WB_PENDING_CHECK_EN
  // Unoccupied slots always hold a cleared valid bit, so every slot can be scanned
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] == chk_rs)) rs_pending = 1'b1;
      if (r_vld[i] && (r_rd[i] == chk_rt)) rt_pending = 1'b1;
    end
    if (WriteEn && (rdAddress == chk_rs)) rs_pending = 1'b1;
    if (WriteEn && (rdAddress == chk_rt)) rt_pending = 1'b1;
    if (chk_rs == 5'd0) rs_pending = 1'b0;
    if (chk_rt == 5'd0) rt_pending = 1'b0;
  end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the register file's single write port; drives its WriteEn, rdAddress and Write_Back.
- Merges two result sources:
  - the in-order pipeline write-back (ALU/load), which has fixed priority and no backpressure;
  - a long-latency unit (mul/div) with valid/ready handshake, whose results are buffered in a small FIFO.
- Results are drained onto the port in free cycles.

Parameters:
- FIFO_DEPTH, 4: number of buffered long-latency results; power of 2, ≥2.
- CW, $clog2(FIFO_DEPTH)+1: width of fifo_count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline write-back request this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- lu_valid  in  1  long-latency result offered.
- lu_rd  in  5  long-latency destination register.
- lu_data  in  32  long-latency result.
- lu_ready  out  1  arbiter can accept a long-latency result.
- WriteEn  out  1  register-file write enable (registered).
- rdAddress  out  5  register-file write address (registered).
- Write_Back  out  32  register-file write data (registered).
- fifo_count  out  CW  number of FIFO slots in use, valid or squashed.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; sampled only on the rising edge of clk.
- Reset values:
  - WriteEn=0, rdAddress=0, Write_Back=0.
  - FIFO empty, fifo_count=0, all entry valid bits cleared.
  - lu_ready=0 while reset is high.
  - An in-flight handshake in the reset cycle is discarded.
- Handshake:
  - Transfer occurs when lu_valid && lu_ready at a rising edge.
  - lu_ready = !reset && (fifo_count < FIFO_DEPTH), computed from current state only. A pop in the same cycle does not raise ready.
  - lu_valid/lu_rd/lu_data must stay stable until the transfer.
- r0 filtering:
  - pipe_we with pipe_rd==0 is treated as no request.
  - An accepted lu transfer with lu_rd==0 completes the handshake but is not enqueued.
- Arbitration, evaluated each cycle; outputs are registered at the edge:
  1. pipe request (pipe_we && pipe_rd!=0): next outputs are WriteEn=1, rdAddress=pipe_rd, Write_Back=pipe_data. The FIFO does not pop.
  2. Else FIFO non-empty: pop the head. Next WriteEn = head valid bit, rdAddress/Write_Back = head contents. A squashed head pops with WriteEn=0.
  3. Else WriteEn=0.
  - When WriteEn=0, rdAddress and Write_Back are driven 0.
- Latency:
  - pipe → WriteEn: 1 cycle.
  - lu transfer → WriteEn: minimum 2 cycles (enqueue, then pop). There is no bypass around the FIFO.
  - A continuous pipe stream starves the FIFO indefinitely; pipeline bubbles guarantee progress.
- Order: FIFO is strict first-in-first-out; long-latency results never reorder among themselves.
- Squash rule:
  - A pipe request to register R clears the valid bit of every queued entry with rd==R in that cycle.
  - A same-cycle lu enqueue to R is not squashed: it is newer.
  - Squashed entries still occupy a slot until popped.
- Simultaneous push and pop: allowed when not full; fifo_count unchanged.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH by construction; never overflows or underflows.

Optional Feature:
- Macro: WB_PENDING_CHECK_EN.
- Defined: adds four ports.
  - chk_rs  in 5, chk_rt  in 5.
  - rs_pending  out 1, rt_pending  out 1 (combinational).
  - rs_pending=1 iff chk_rs!=0 and any valid queued entry, or the registered output with WriteEn=1, has rd==chk_rs. rt_pending likewise for chk_rt.
  - Decode uses these to stall on RAW hazards against results not yet written.
- Undefined: ports absent; no comparators synthesized.

Test Plan:
- Reset, then idle: hold reset 2 cycles, release → WriteEn=0, fifo_count=0, lu_ready=1 on the first cycle after release.
- Pipe only: pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF → next cycle WriteEn=1, rdAddress=5, Write_Back=0xDEADBEEF.
- Conflict and drain:
  - Same cycle: pipe (rd=3, 0x11) and lu (rd=7, 0x22) → cycle+1 writes r3=0x11.
  - Pipe idle afterwards → cycle+2 writes r7=0x22.
- Full FIFO and r0 drop:
  - pipe_we held 1 (rd=1); push 4 lu results (rd 8..11) → fifo_count=4, lu_ready=0.
  - 5th lu_valid (rd=12) waits while lu_ready=0.
  - Drop pipe_we → pops r8, r9, r10, r11 in order on consecutive cycles; r12 accepted once lu_ready=1.
  - Accepted lu with lu_rd=0 → not enqueued, no write to r0.
- Squash and mid-operation reset:
  - Queue rd=9 value 0xAA, then pipe write r9=0xBB → r9=0xBB written; later pop of the 0xAA entry yields WriteEn=0.
  - Assert reset with 3 entries queued → fifo_count=0 and no further writes.
- (WB_PENDING_CHECK_EN) Queued entry rd=6, chk_rs=6, chk_rt=0 → rs_pending=1, rt_pending=0. After the r6 write completes → rs_pending=0.
